// File: rtl/fifo_wr_bridge.sv
// -----------------------------------------------------------------------------
// fifo_wr_bridge
//
// Purpose:
//   Bridges an upstream valid/ready stream with frame markers (s_last) onto the
//   write port of an asynchronous FIFO. Incoming words go into a two-entry skid
//   buffer so that s_ready can come straight from a flop. The head word is
//   presented on fifo_data/fifo_wr_en until the FIFO takes it (fifo_full low at
//   a clock edge). Every consumed word that carries last=1 closes a frame and
//   increments frame_cnt.
//
// Configuration:
//   FIFO_WR_BRIDGE_HDR_EN  When defined, every frame is preceded by a header
//                          word equal to the low DATA_WIDTH bits of frame_cnt
//                          (zero-extended when CNT_WIDTH < DATA_WIDTH). The
//                          header does not count as a frame. When undefined,
//                          only stream words are written.
//
// Parameters:
//   DATA_WIDTH  width of stream words and FIFO write data (default 8)
//   CNT_WIDTH   width of the frame counter (default 16)
//
// Ports:
//   clk_wr      write-domain clock, all logic on its rising edge
//   rst_n       asynchronous active-low reset
//   s_data      upstream word
//   s_valid     upstream word valid
//   s_last      upstream word is the final word of its frame
//   s_ready     bridge accepts a word this cycle (registered)
//   fifo_data   word presented to the FIFO data_in
//   fifo_wr_en  word presented to the FIFO (drives wr_en)
//   fifo_full   FIFO full flag, write domain
//   frame_cnt   number of frames fully written, wraps modulo 2^CNT_WIDTH
//   busy        a word is buffered or a frame is still open
// -----------------------------------------------------------------------------
module fifo_wr_bridge #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_wr,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_wr_en,
   input  logic                  fifo_full,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BODY = 2'd1
`ifdef FIFO_WR_BRIDGE_HDR_EN
      ,
      ST_HDR  = 2'd2
`endif
   } state_e;

   state_e                state_q;
   state_e                state_d;

   // Skid buffer: entry 0 is always the head (oldest word).
   logic [1:0]            occ_q;
   logic [1:0]            occ_d;
   logic [DATA_WIDTH-1:0] data0_q;
   logic [DATA_WIDTH-1:0] data0_d;
   logic [DATA_WIDTH-1:0] data1_q;
   logic [DATA_WIDTH-1:0] data1_d;
   logic                  last0_q;
   logic                  last0_d;
   logic                  last1_q;
   logic                  last1_d;

   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_d;

   // Registered copy of (occupancy < 2); held low while in reset.
   logic                  rdy_q;
   logic                  rdy_d;

   logic                  accept;
   logic                  data_present;
   logic                  pop;

`ifdef FIFO_WR_BRIDGE_HDR_EN
   logic                  hdr_present;
   logic                  hdr_pop;
   logic [DATA_WIDTH-1:0] hdr_word;

   // The header carries the index of the frame it precedes, i.e. the count of
   // frames completed so far, fitted to the data width.
   if (CNT_WIDTH >= DATA_WIDTH) begin : g_hdr_trunc
      assign hdr_word = cnt_q[DATA_WIDTH-1:0];
   end else begin : g_hdr_ext
      assign hdr_word = {{(DATA_WIDTH-CNT_WIDTH){1'b0}}, cnt_q};
   end
`endif

   // Handshake and presentation. In header mode the buffered data of a new
   // frame is held back until its header has been taken by the FIFO.
   always_comb begin
      accept       = s_valid && rdy_q;
`ifdef FIFO_WR_BRIDGE_HDR_EN
      hdr_present  = (state_q == ST_HDR);
      hdr_pop      = hdr_present && !fifo_full;
      data_present = (state_q == ST_BODY) && (occ_q != 2'd0);
`else
      data_present = (occ_q != 2'd0);
`endif
      pop          = data_present && !fifo_full;
   end

   // FIFO write port is driven only from registered state, so the word and
   // its enable stay stable for as long as the FIFO stays full.
   always_comb begin
      fifo_wr_en = data_present;
      fifo_data  = '0;
      if (data_present) begin
         fifo_data = data0_q;
      end
`ifdef FIFO_WR_BRIDGE_HDR_EN
      if (hdr_present) begin
         fifo_wr_en = 1'b1;
         fifo_data  = hdr_word;
      end
`endif
   end

   // Skid buffer update. A pop shifts entry 1 into the head; an accepted word
   // then lands in the first free slot after that shift. An accept together
   // with a pop can only happen at occupancy 1, so that word goes to the head.
   always_comb begin
      data0_d = data0_q;
      data1_d = data1_q;
      last0_d = last0_q;
      last1_d = last1_q;
      occ_d   = occ_q;

      if (pop) begin
         data0_d = data1_q;
         last0_d = last1_q;
      end

      if (accept) begin
         if (pop || (occ_q == 2'd0)) begin
            data0_d = s_data;
            last0_d = s_last;
         end else begin
            data1_d = s_data;
            last1_d = s_last;
         end
      end

      case ({accept, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase

      rdy_d = (occ_d != 2'd2);
   end

   // A frame is complete only when its last word actually leaves the bridge.
   always_comb begin
      cnt_d = cnt_q;
      if (pop && last0_q) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // Frame state. After a last word is consumed, anything still buffered
   // belongs to the next frame, which in header mode needs its own header.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
`ifdef FIFO_WR_BRIDGE_HDR_EN
               state_d = ST_HDR;
`else
               state_d = ST_BODY;
`endif
            end
         end
         ST_BODY: begin
            if (pop && last0_q) begin
               if (occ_d == 2'd0) begin
                  state_d = ST_IDLE;
               end else begin
`ifdef FIFO_WR_BRIDGE_HDR_EN
                  state_d = ST_HDR;
`else
                  state_d = ST_BODY;
`endif
               end
            end
         end
`ifdef FIFO_WR_BRIDGE_HDR_EN
         ST_HDR: begin
            if (hdr_pop) begin
               state_d = ST_BODY;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers. Reset drops all buffered words and any open frame.
   always_ff @(posedge clk_wr or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         occ_q   <= 2'd0;
         data0_q <= '0;
         data1_q <= '0;
         last0_q <= 1'b0;
         last1_q <= 1'b0;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         last0_q <= last0_d;
         last1_q <= last1_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
      end
   end

   assign s_ready   = rdy_q;
   assign frame_cnt = cnt_q;
   assign busy      = (state_q != ST_IDLE) || (occ_q != 2'd0);

endmodule

// File: tb/tb_fifo_wr_bridge.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_bridge
//
// Directed bench for fifo_wr_bridge with DATA_WIDTH=8 and CNT_WIDTH=4 so the
// frame counter wraps quickly. Inputs change on the falling edge; outputs are
// observed on the falling edge after the rising edge that used those inputs.
// Words taken by the FIFO are logged just before the rising edge that takes
// them and compared against hand-written expected sequences.
// -----------------------------------------------------------------------------
module tb_fifo_wr_bridge;

   logic       clk_wr;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic [7:0] fifo_data;
   logic       fifo_wr_en;
   logic       fifo_full;
   logic [3:0] frame_cnt;
   logic       busy;

   int         vectors;
   int         miscompares;
   logic [7:0] got[$];
   logic [7:0] expq[$];

   fifo_wr_bridge #(
      .DATA_WIDTH(8),
      .CNT_WIDTH (4)
   ) dut (
      .clk_wr    (clk_wr),
      .rst_n     (rst_n),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .fifo_data (fifo_data),
      .fifo_wr_en(fifo_wr_en),
      .fifo_full (fifo_full),
      .frame_cnt (frame_cnt),
      .busy      (busy)
   );

   initial clk_wr = 1'b0;
   always #5 clk_wr = ~clk_wr;

   // One comparison: counts the vector, flags and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, log the word the FIFO will
   // take at the coming rising edge, then advance to the next falling edge.
   task automatic applyStimulus(input logic v, input logic [7:0] d,
                                input logic l, input logic f);
      s_valid   = v;
      s_data    = d;
      s_last    = l;
      fifo_full = f;
      if (fifo_wr_en && !fifo_full) begin
         got.push_back(fifo_data);
      end
      @(negedge clk_wr);
   endtask

   // Compare the logged FIFO writes against expq, then clear the log.
   task automatic checkStream(input string tag);
      checkOutput({tag, "_count"}, 32'(got.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size(); i++) begin
         if (i < got.size()) begin
            checkOutput($sformatf("%s_word%0d", tag, i), 32'(got[i]), 32'(expq[i]));
         end
      end
      got.delete();
   endtask

   task automatic doReset();
      s_valid   = 1'b0;
      s_data    = 8'h00;
      s_last    = 1'b0;
      fifo_full = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk_wr);
      rst_n = 1'b1;
      @(negedge clk_wr);
      got.delete();
   endtask

   initial begin
      logic [7:0] f1[4];
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      s_valid     = 1'b0;
      s_data      = 8'h00;
      s_last      = 1'b0;
      fifo_full   = 1'b0;

      $display("[TB] start");

      // Reset values while rst_n is held low.
      repeat (2) @(negedge clk_wr);
      checkOutput("rst_s_ready", 32'(s_ready), 0);
      checkOutput("rst_wr_en", 32'(fifo_wr_en), 0);
      checkOutput("rst_data", 32'(fifo_data), 0);
      checkOutput("rst_frame_cnt", 32'(frame_cnt), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      @(negedge clk_wr);
      checkOutput("post_rst_s_ready", 32'(s_ready), 1);

`ifndef FIFO_WR_BRIDGE_HDR_EN
      // Four-word frame with the FIFO never full.
      f1 = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, f1[i], (i == 3), 1'b0);
         checkOutput($sformatf("f1_wr_en%0d", i), 32'(fifo_wr_en), 1);
         checkOutput($sformatf("f1_data%0d", i), 32'(fifo_data), 32'(f1[i]));
         if (i == 0) begin
            checkOutput("f1_busy_open", 32'(busy), 1);
            checkOutput("f1_cnt_open", 32'(frame_cnt), 0);
         end
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("f1_wr_en_end", 32'(fifo_wr_en), 0);
      checkOutput("f1_frame_cnt", 32'(frame_cnt), 1);
      checkOutput("f1_busy_end", 32'(busy), 0);
      expq = '{8'h11, 8'h22, 8'h33, 8'h44};
      checkStream("f1");

      // Continuous stream with the FIFO full for three cycles mid-frame.
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
      checkOutput("bp_data_a", 32'(fifo_data), 32'h01);
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b1);
      checkOutput("bp_data_b", 32'(fifo_data), 32'h01);
      checkOutput("bp_ready_b", 32'(s_ready), 0);
      applyStimulus(1'b1, 8'h03, 1'b0, 1'b1);
      checkOutput("bp_data_c", 32'(fifo_data), 32'h01);
      checkOutput("bp_ready_c", 32'(s_ready), 0);
      applyStimulus(1'b1, 8'h03, 1'b0, 1'b1);
      checkOutput("bp_data_d", 32'(fifo_data), 32'h01);
      checkOutput("bp_wr_en_d", 32'(fifo_wr_en), 1);
      applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
      checkOutput("bp_data_e", 32'(fifo_data), 32'h02);
      checkOutput("bp_ready_e", 32'(s_ready), 1);
      applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
      checkOutput("bp_data_f", 32'(fifo_data), 32'h03);
      applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
      checkOutput("bp_data_g", 32'(fifo_data), 32'h04);
      applyStimulus(1'b1, 8'h05, 1'b1, 1'b0);
      checkOutput("bp_data_h", 32'(fifo_data), 32'h05);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("bp_frame_cnt", 32'(frame_cnt), 2);
      checkOutput("bp_busy", 32'(busy), 0);
      expq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      checkStream("bp");

      // Three single-word frames back to back.
      doReset();
      applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
      checkOutput("sw_wr_en", 32'(fifo_wr_en), 1);
      checkOutput("sw_cnt_mid", 32'(frame_cnt), 2);
      checkOutput("sw_busy_mid", 32'(busy), 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("sw_frame_cnt", 32'(frame_cnt), 3);
      checkOutput("sw_busy_end", 32'(busy), 0);
      expq = '{8'hA5, 8'hA5, 8'hA5};
      checkStream("sw");

      // Seventeen frames wrap the 4-bit counter through 15, 0, 1.
      doReset();
      expq.delete();
      for (int k = 1; k <= 17; k++) begin
         applyStimulus(1'b1, 8'(k), 1'b1, 1'b0);
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
         expq.push_back(8'(k));
         if (k == 15) checkOutput("wrap_cnt15", 32'(frame_cnt), 15);
         if (k == 16) checkOutput("wrap_cnt16", 32'(frame_cnt), 0);
         if (k == 17) checkOutput("wrap_cnt17", 32'(frame_cnt), 1);
      end
      checkStream("wrap");

      // Reset with two words stuck behind a full FIFO.
      applyStimulus(1'b1, 8'hB1, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'hB2, 1'b0, 1'b1);
      checkOutput("mr_ready_full", 32'(s_ready), 0);
      checkOutput("mr_data_full", 32'(fifo_data), 32'hB1);
      s_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      checkOutput("mr_wr_en", 32'(fifo_wr_en), 0);
      checkOutput("mr_data", 32'(fifo_data), 0);
      checkOutput("mr_frame_cnt", 32'(frame_cnt), 0);
      checkOutput("mr_busy", 32'(busy), 0);
      checkOutput("mr_ready", 32'(s_ready), 0);
      fifo_full = 1'b0;
      @(negedge clk_wr);
      rst_n = 1'b1;
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("mr_wr_en_after", 32'(fifo_wr_en), 0);
      checkOutput("mr_ready_after", 32'(s_ready), 1);
      applyStimulus(1'b1, 8'hC1, 1'b1, 1'b0);
      checkOutput("mr_data_new", 32'(fifo_data), 32'hC1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("mr_frame_cnt_new", 32'(frame_cnt), 1);
      expq = '{8'hC1};
      checkStream("mr");
`else
      // Header mode: frames 0x10,0x20(last) and 0x30(last).
      applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
      checkOutput("hdr_wr_en_a", 32'(fifo_wr_en), 1);
      checkOutput("hdr_data_a", 32'(fifo_data), 32'h00);
      applyStimulus(1'b1, 8'h20, 1'b1, 1'b0);
      checkOutput("hdr_data_b", 32'(fifo_data), 32'h10);
      checkOutput("hdr_ready_b", 32'(s_ready), 0);
      applyStimulus(1'b1, 8'h30, 1'b1, 1'b0);
      checkOutput("hdr_data_c", 32'(fifo_data), 32'h20);
      applyStimulus(1'b1, 8'h30, 1'b1, 1'b0);
      checkOutput("hdr_data_d", 32'(fifo_data), 32'h01);
      checkOutput("hdr_cnt_d", 32'(frame_cnt), 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("hdr_data_e", 32'(fifo_data), 32'h30);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("hdr_frame_cnt", 32'(frame_cnt), 2);
      checkOutput("hdr_busy", 32'(busy), 0);
      expq = '{8'h00, 8'h10, 8'h20, 8'h01, 8'h30};
      checkStream("hdr");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
